// File: rtl/branch_history_tracker.sv
// branch_history_tracker
// Keeps the speculative global branch history (SH) used for predictor lookup
// and the architectural history (AH) built from retiring branches. Every
// accepted prediction saves the pre-branch SH into a circular checkpoint
// array. A mispredict rolls SH back to the saved entry plus the real
// direction. A flush replaces SH with AH.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   IN_predValid/Taken  conditional branch predicted this cycle, direction
//   OUT_predReady       a free checkpoint slot exists
//   OUT_predCkptID      checkpoint ID given to the current prediction
//   OUT_history         speculative history for predictor lookup
//   IN_mispred*         resolved mispredict: checkpoint ID, actual direction
//   IN_commit*          oldest in-flight branch retires, actual direction
//   OUT_commitHistory   pre-branch history of the oldest checkpoint
//   IN_flush            discard all speculative state
module branch_history_tracker #(
    parameter int HIST_LEN = 16,
    parameter int DEPTH    = 8,
    parameter int ID_W     = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                IN_predValid,
    input  logic                IN_predTaken,
    output logic                OUT_predReady,
    output logic [ID_W-1:0]     OUT_predCkptID,
    output logic [HIST_LEN-1:0] OUT_history,
    input  logic                IN_mispredValid,
    input  logic [ID_W-1:0]     IN_mispredCkptID,
    input  logic                IN_mispredTaken,
    input  logic                IN_commitValid,
    input  logic                IN_commitTaken,
    output logic [HIST_LEN-1:0] OUT_commitHistory,
    input  logic                IN_flush
);

    localparam logic [ID_W:0]   FULL_COUNT = DEPTH[ID_W:0];
    localparam logic [ID_W:0]   CNT_ZERO   = (ID_W+1)'(1'b0);
    localparam logic [ID_W:0]   CNT_ONE    = (ID_W+1)'(1'b1);
    localparam logic [ID_W-1:0] ID_ZERO    = ID_W'(1'b0);
    localparam logic [ID_W-1:0] ID_ONE     = ID_W'(1'b1);
    localparam logic [HIST_LEN-1:0] HIST_ZERO = HIST_LEN'(1'b0);

    logic [HIST_LEN-1:0] sh_r;
    logic [HIST_LEN-1:0] ah_r;
    logic [HIST_LEN-1:0] ck_r [DEPTH];
    logic [ID_W-1:0]     head_r;
    logic [ID_W-1:0]     tail_r;
    logic [ID_W:0]       count_r;

    logic [HIST_LEN-1:0] sh_nxt_s;
    logic [HIST_LEN-1:0] ah_nxt_s;
    logic [ID_W-1:0]     head_nxt_s;
    logic [ID_W-1:0]     tail_nxt_s;
    logic [ID_W:0]       count_nxt_s;
    logic                ck_we_s;

    logic                pred_ready_s;
    logic                commit_s;
    logic [ID_W:0]       commit_dec_s;
    logic [ID_W-1:0]     mis_off_s;
    logic                mis_live_s;
    logic                mispred_s;
    logic                accept_s;

    // Only registered state reaches the outputs, so there is no input-to-output path.
    assign pred_ready_s      = (count_r < FULL_COUNT);
    assign OUT_predReady     = pred_ready_s;
    assign OUT_predCkptID    = tail_r;
    assign OUT_history       = sh_r;
    assign OUT_commitHistory = ck_r[head_r];

    // Event qualification: commit needs a live branch; a mispredict ID must
    // lie in [head, tail), tested as its age from head against count.
    always_comb begin
        commit_s     = IN_commitValid && (count_r != CNT_ZERO);
        commit_dec_s = commit_s ? CNT_ONE : CNT_ZERO;
        mis_off_s    = IN_mispredCkptID - head_r;
        mis_live_s   = ({1'b0, mis_off_s} < count_r);
        mispred_s    = IN_mispredValid && mis_live_s && !IN_flush;
        accept_s     = IN_predValid && pred_ready_s && !IN_mispredValid && !IN_flush;
    end

    // Next-state selection: commit always applies, then flush > mispredict > prediction.
    always_comb begin
        head_nxt_s  = commit_s ? (head_r + ID_ONE) : head_r;
        ah_nxt_s    = commit_s ? {ah_r[HIST_LEN-2:0], IN_commitTaken} : ah_r;
        sh_nxt_s    = sh_r;
        tail_nxt_s  = tail_r;
        count_nxt_s = count_r - commit_dec_s;
        ck_we_s     = 1'b0;
        if (IN_flush) begin
            sh_nxt_s    = ah_nxt_s;
            tail_nxt_s  = head_nxt_s;
            count_nxt_s = CNT_ZERO;
        end else if (mispred_s) begin
            // Keep the mispredicted branch itself, drop everything younger.
            sh_nxt_s    = {ck_r[IN_mispredCkptID][HIST_LEN-2:0], IN_mispredTaken};
            tail_nxt_s  = IN_mispredCkptID + ID_ONE;
            count_nxt_s = {1'b0, mis_off_s} + CNT_ONE - commit_dec_s;
        end else if (accept_s) begin
            sh_nxt_s    = {sh_r[HIST_LEN-2:0], IN_predTaken};
            tail_nxt_s  = tail_r + ID_ONE;
            count_nxt_s = count_r + CNT_ONE - commit_dec_s;
            ck_we_s     = 1'b1;
        end else begin
            ck_we_s     = 1'b0;
        end
    end

    // History, pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_r    <= HIST_ZERO;
            ah_r    <= HIST_ZERO;
            head_r  <= ID_ZERO;
            tail_r  <= ID_ZERO;
            count_r <= CNT_ZERO;
        end else begin
            sh_r    <= sh_nxt_s;
            ah_r    <= ah_nxt_s;
            head_r  <= head_nxt_s;
            tail_r  <= tail_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // Checkpoint storage: not reset; written with the pre-branch history on accept.
    always_ff @(posedge clk) begin
        if (!rst && ck_we_s) begin
            ck_r[tail_r] <= sh_r;
        end
    end

endmodule
